// File: rtl/uart_tx_sched.sv
// UART TX scheduler: round-robin byte arbitration across requesters and the
// START/DATA/PARITY/CRC/STOP sequencing that steers the TX datapath.
`timescale 1ns/1ps

module uart_tx_sched #(
    parameter int N_REQ = 2,
    parameter int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [8*N_REQ-1:0]   data_i,
    input  logic [N_REQ-1:0]     parity_en_i,
    input  logic [N_REQ-1:0]     crc_en_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [N_REQ-1:0]     done_o,
    output logic                 busy_o,
    input  logic                 trigger_i,
    input  logic                 start_tx_i,
    input  logic [4:0]           bit_cnt_i,
    output logic [7:0]           data_o,
    output logic                 crc_en_o,
    output logic                 tx_start_cmd_o,
    output logic                 changed_tx_state_o,
    output logic                 is_tx_idle_o,
    output logic                 is_tx_start_o,
    output logic                 is_tx_data_o,
    output logic                 is_tx_pairity_o,
    output logic                 is_tx_crc_o,
    output logic                 is_tx_stop_o,
    output logic [2:0]           state_dbg_o
);

    // Handshake req_i[k]/ack_o[k]: req is a level that the requester holds,
    // together with its byte and enables, until ack; ack is a one-cycle
    // accept pulse. A req withdrawn before its ack is simply never served.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_CRC    = 3'd5,
        S_STOP   = 3'd6
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic             par_en_q;

    logic [N_REQ-1:0] req_rot;
    logic [IDX_W-1:0] rot_pos;
    logic [IDX_W:0]   win_sum;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] next_ptr;
    logic [7:0]       win_data;
    logic             win_par;
    logic             win_crc;
    logic [N_REQ-1:0] win_onehot;
    logic [N_REQ-1:0] owner_onehot;
    logic             grant;
    logic             step;

    // Rotate requests so that bit 0 is the requester rr_ptr points at.
    assign req_rot = N_REQ'({req_i, req_i} >> rr_ptr_q);

    always_comb begin
        rot_pos = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_pos = i[IDX_W-1:0];
            end
        end
    end

    assign win_sum  = {1'b0, rr_ptr_q} + {1'b0, rot_pos};
    assign win_idx  = (win_sum >= (IDX_W+1)'(N_REQ))
                    ? IDX_W'(win_sum - (IDX_W+1)'(N_REQ))
                    : win_sum[IDX_W-1:0];
    assign next_ptr = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        win_data = '0;
        win_par  = 1'b0;
        win_crc  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_data = data_i[8*k +: 8];
                win_par  = parity_en_i[k];
                win_crc  = crc_en_i[k];
            end
        end
    end

    assign win_onehot   = N_REQ'(1) << win_idx;
    assign owner_onehot = N_REQ'(1) << owner_q;

    // A state ends on its last bit: single-bit states always, byte states at bit 7.
    always_comb begin
        changed_tx_state_o = 1'b0;
        case (state_q)
            S_START, S_PARITY, S_STOP: changed_tx_state_o = 1'b1;
            S_DATA, S_CRC:             changed_tx_state_o = (bit_cnt_i == 5'd7);
            default:                   changed_tx_state_o = 1'b0;
        endcase
    end

    assign step  = trigger_i & changed_tx_state_o;
    assign grant = (state_q == S_IDLE) & (|req_i);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (grant) state_d = S_ARM;
            end
            S_ARM: begin
                if (trigger_i && start_tx_i) state_d = S_START;
            end
            S_START: begin
                if (step) state_d = S_DATA;
            end
            S_DATA: begin
                if (step) begin
                    if (par_en_q)      state_d = S_PARITY;
                    else if (crc_en_o) state_d = S_CRC;
                    else               state_d = S_STOP;
                end
            end
            S_PARITY: begin
                if (step) state_d = crc_en_o ? S_CRC : S_STOP;
            end
            S_CRC: begin
                if (step) state_d = S_STOP;
            end
            S_STOP: begin
                if (step) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q       <= '0;
            owner_q        <= '0;
            data_o         <= '0;
            crc_en_o       <= 1'b0;
            par_en_q       <= 1'b0;
            ack_o          <= '0;
            done_o         <= '0;
            tx_start_cmd_o <= 1'b0;
        end else begin
            ack_o          <= '0;
            done_o         <= '0;
            tx_start_cmd_o <= 1'b0;
            if (grant) begin
                rr_ptr_q       <= next_ptr;
                owner_q        <= win_idx;
                data_o         <= win_data;
                crc_en_o       <= win_crc;
                par_en_q       <= win_par;
                ack_o          <= win_onehot;
                tx_start_cmd_o <= 1'b1;
            end
            if (state_q == S_STOP && step) begin
                done_o <= owner_onehot;
            end
        end
    end

    // ARM still reports idle to the datapath: the frame has not started yet.
    assign is_tx_idle_o    = (state_q == S_IDLE) || (state_q == S_ARM);
    assign is_tx_start_o   = (state_q == S_START);
    assign is_tx_data_o    = (state_q == S_DATA);
    assign is_tx_pairity_o = (state_q == S_PARITY);
    assign is_tx_crc_o     = (state_q == S_CRC);
    assign is_tx_stop_o    = (state_q == S_STOP);
    assign busy_o          = (state_q != S_IDLE);
    assign state_dbg_o     = state_q;

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Control/arbitration block that sequences the UART TX datapath.
- Arbitrates round-robin among N_REQ byte requesters and latches the winning byte and its frame options.
- Drives the datapath's one-hot state flags, the state-change strobe and the start command, and reports per-requester completion.
- Sits between the requester ports and the TX datapath; the datapath supplies the baud trigger, the start-flag echo and bit_cnt.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- IDX_W, $clog2(N_REQ) (minimum 1), width of the owner index and round-robin pointer.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset, asynchronous, active-high
- req_i  input  N_REQ  per-requester byte request (level)
- data_i  input  8*N_REQ  byte for requester k in bits [8k+7:8k]
- parity_en_i  input  N_REQ  per-requester parity-bit enable
- crc_en_i  input  N_REQ  per-requester CRC-byte enable
- ack_o  output  N_REQ  one-cycle pulse: byte k accepted
- done_o  output  N_REQ  one-cycle pulse: frame k fully sent (end of stop bit)
- busy_o  output  1  high from grant until return to IDLE
- trigger_i  input  1  baud tick from datapath timing
- start_tx_i  input  1  datapath's armed-start flag
- bit_cnt_i  input  5  datapath bit counter
- data_o  output  8  latched byte to datapath
- crc_en_o  output  1  latched CRC enable to datapath
- tx_start_cmd_o  output  1  one-cycle start command to datapath
- changed_tx_state_o  output  1  combinational: last bit of the current state
- is_tx_idle_o, is_tx_start_o, is_tx_data_o, is_tx_pairity_o, is_tx_crc_o, is_tx_stop_o  output  1 each  one-hot state decode

Behaviour:
- States: IDLE, ARM, START, DATA, PARITY, CRC, STOP. Encoding is free; the is_tx_* outputs are its one-hot decode. ARM decodes as is_tx_idle_o=1.
- Reset (asynchronous):
  - state=IDLE, rr_ptr=0, owner=0, data_o=0, crc_en_o=0, latched parity enable=0.
  - ack_o=0, done_o=0, tx_start_cmd_o=0, busy_o=0.
  - is_tx_idle_o=1; all other is_tx_* =0.
  - Reset mid-frame abandons the frame; no done_o is issued.
- IDLE with |req_i:
  - Winner: first set bit searching upward from rr_ptr, wrapping.
  - Next edge: latch data_o, crc_en_o, parity enable and owner from the winner; pulse ack_o[winner] and tx_start_cmd_o for 1 cycle; rr_ptr <= (winner+1) mod N_REQ; busy_o=1; go to ARM.
  - Grant latency is 1 cycle from req visible in IDLE.
- ARM: on (trigger_i & start_tx_i) -> START. start_tx_i is ignored without trigger_i.
- changed_tx_state_o is high when any of these holds; otherwise 0 (including IDLE and ARM):
  - state is START, PARITY or STOP;
  - state is DATA and bit_cnt_i==7;
  - state is CRC and bit_cnt_i==7.
- Transitions occur only on trigger_i & changed_tx_state_o:
  - START -> DATA.
  - DATA -> PARITY if parity enabled; else CRC if crc_en_o; else STOP.
  - PARITY -> CRC if crc_en_o; else STOP.
  - CRC -> STOP.
  - STOP -> IDLE, with a done_o[owner] pulse on the following cycle and busy_o cleared.
- Frame length in triggers from START entry to IDLE: 10 + parity + 8*crc (10, 11, 18 or 19).
- IDLE is re-entered with no idle gap: a pending request may be granted in the first IDLE cycle. The done_o and ack_o pulses may coincide for different requesters.
- data_o and the latched options are stable from grant until return to IDLE. Changes on req_i, data_i or the enables during a frame have no effect.
- Requests are level-sensitive: a requester holds req and data until its ack. Keeping req high after ack queues the next byte, and round-robin then serves the others first.
- A req dropped before grant is never acked.
- Out-of-range bit_cnt_i (>7) in DATA/CRC: no transition; counter wrap is the datapath's concern.

Test Plan:
- Single byte, N_REQ=2: req_i=01, data 0xA5, parity on, CRC off -> ack_o=01 one cycle later, tx_start_cmd_o 1 cycle, START/DATA(8)/PARITY/STOP, 11 triggers, done_o=01 after STOP, busy_o low.
- CRC frame: parity off, CRC on, data 0x31 -> DATA->CRC->STOP, crc_en_o=1 throughout, 18 triggers, changed_tx_state_o only at bit_cnt_i==7 in DATA/CRC.
- Round-robin: req_i=11 held for 4 frames -> grant order 0,1,0,1, each ack preceding its frame, no idle gap between STOP exit and next ack.
- ARM gating: start_tx_i high without trigger_i for 5 cycles -> state stays ARM; first trigger_i -> START.
- Mid-frame input change: data_i altered during DATA -> data_o unchanged until IDLE.
- Reset asserted in DATA bit 4 -> all outputs immediately at reset values, no done_o; after release, held req re-granted from rr_ptr=0.
